// File: rtl/math_acc.sv
// rtl/math_acc.sv - windowed sum/avg/min/max accumulator with one held result
module math_acc #(
    parameter int WIN_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset_vio_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        clear,
    output logic [11:0] out_sum,
    output logic [7:0]  out_avg,
    output logic [7:0]  out_min,
    output logic [7:0]  out_max,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  drop_cnt
);
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state;
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [CW-1:0] cnt;
    logic [11:0]   acc_sum;
    logic [7:0]    acc_min;
    logic [7:0]    acc_max;

    // Assert immediately, release only after two clean clock edges.
    always_ff @(posedge clk or negedge reset_vio_n) begin
        if (!reset_vio_n) rst_sync <= 2'b00;
        else              rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic        complete;
    logic        xfer;
    logic [11:0] fin_sum;
    logic [7:0]  fin_min;
    logic [7:0]  fin_max;

    always_comb begin
        complete = in_valid && !clear && (cnt == LAST);
        xfer     = (state == HOLD) && out_ready;
        fin_sum  = acc_sum + {4'b0000, in_data};
        fin_min  = (in_data < acc_min) ? in_data : acc_min;
        fin_max  = (in_data > acc_max) ? in_data : acc_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_min   <= '0;
            out_max   <= '0;
            drop_cnt  <= '0;
            cnt       <= '0;
            acc_sum   <= '0;
            acc_min   <= '0;
            acc_max   <= '0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (in_valid) begin
                if (!complete) begin
                    // cnt==0 marks a fresh window: load rather than compare
                    if (cnt == '0) begin
                        acc_sum <= {4'b0000, in_data};
                        acc_min <= in_data;
                        acc_max <= in_data;
                    end else begin
                        acc_sum <= fin_sum;
                        acc_min <= fin_min;
                        acc_max <= fin_max;
                    end
                    cnt <= cnt + CW'(1);
                end else if (state == ACCUM || xfer) begin
                    out_sum <= fin_sum;
                    out_avg <= 8'(fin_sum >> WIN_LOG2);
                    out_min <= fin_min;
                    out_max <= fin_max;
                    cnt     <= '0;
                    acc_sum <= '0;
                end else if (drop_cnt != 8'hFF) begin
                    // result buffer still occupied; accumulator stays at N-1
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end

            case (state)
                ACCUM: begin
                    if (complete) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (xfer && !complete) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_math_acc.sv
// tb/tb_math_acc.sv - scoreboard bench for math_acc
module tb_math_acc;
    logic        clk = 1'b0;
    logic        reset_vio_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] out_sum;
    logic [7:0]  out_avg, out_min, out_max, drop_cnt;
    logic        out_valid;

    logic        in_valid16 = 1'b0;
    logic        out_ready16 = 1'b0;
    logic [11:0] out_sum16;
    logic [7:0]  out_avg16, out_min16, out_max16, drop_cnt16;
    logic        out_valid16;

    int n_tests = 0;
    int n_fail  = 0;
    logic [35:0] exp_q[$];
    logic [35:0] exp_q16[$];

    always #5 clk = ~clk;

    math_acc #(.WIN_LOG2(2)) dut (
        .clk(clk), .reset_vio_n(reset_vio_n), .in_data(in_data), .in_valid(in_valid),
        .clear(clear), .out_sum(out_sum), .out_avg(out_avg), .out_min(out_min),
        .out_max(out_max), .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    math_acc #(.WIN_LOG2(4)) dut16 (
        .clk(clk), .reset_vio_n(reset_vio_n), .in_data(in_data), .in_valid(in_valid16),
        .clear(1'b0), .out_sum(out_sum16), .out_avg(out_avg16), .out_min(out_min16),
        .out_max(out_max16), .out_valid(out_valid16), .out_ready(out_ready16), .drop_cnt(drop_cnt16)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [35:0] res(input int s, input int a, input int mn, input int mx);
        return {12'(s), 8'(a), 8'(mn), 8'(mx)};
    endfunction

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected result", {out_sum, out_avg, out_min, out_max}, '0);
            else chk("result", {out_sum, out_avg, out_min, out_max}, exp_q.pop_front());
        end
        if (out_valid16 && out_ready16) begin
            if (exp_q16.size() == 0) chk("unexpected result16", {out_sum16, out_avg16, out_min16, out_max16}, '0);
            else chk("result16", {out_sum16, out_avg16, out_min16, out_max16}, exp_q16.pop_front());
        end
    end

    task automatic send(input logic [7:0] d);
        in_data = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send16(input logic [7:0] d);
        in_data = d; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("reset outputs", {out_valid, out_sum, out_avg, out_min, out_max, drop_cnt},
            {1'b0, 12'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        reset_vio_n = 1'b1;
        cycles(3);

        // basic window, accepted immediately
        exp_q.push_back(res(100, 25, 10, 40));
        send(10); send(20); send(30); send(40);
        chk("valid after Nth", out_valid, 1);
        cycles(1);
        chk("valid one cycle", out_valid, 0);

        // held result, partial next window, then drops
        out_ready = 1'b0;
        exp_q.push_back(res(1020, 255, 255, 255));
        for (int i = 0; i < 12; i++) send(8'd255);
        chk("hold valid", out_valid, 1);
        chk("hold sum stable", out_sum, 1020);
        chk("drop_cnt 5", drop_cnt, 5);
        out_ready = 1'b1;
        cycles(1);
        chk("valid low after transfer", out_valid, 0);

        // clear with the 3rd sample of a window
        clear = 1'b1; cycles(1); clear = 1'b0;
        send(50); send(60);
        clear = 1'b1; send(70); clear = 1'b0;
        exp_q.push_back(res(10, 2, 1, 4));
        send(1); send(2); send(3); send(4);
        cycles(1);
        chk("valid low after clear window", out_valid, 0);
        chk("drop_cnt kept", drop_cnt, 5);

        // Nth sample coincides with transfer
        out_ready = 1'b0;
        exp_q.push_back(res(32, 8, 8, 8));
        exp_q.push_back(res(106, 26, 1, 100));
        send(8); send(8); send(8); send(8);
        send(1); send(2); send(3);
        out_ready = 1'b1;
        send(100);
        chk("valid continuous", out_valid, 1);
        chk("back-to-back sum", out_sum, 106);
        chk("no drop", drop_cnt, 5);
        cycles(1);
        chk("valid low after second", out_valid, 0);

        // asynchronous reset mid-HOLD
        out_ready = 1'b0;
        send(9); send(9); send(9); send(9);
        chk("hold before reset", out_valid, 1);
        #2 reset_vio_n = 1'b0;
        #1;
        chk("async reset outputs", {out_valid, out_sum, out_avg, out_min, out_max, drop_cnt},
            {1'b0, 12'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        #1 reset_vio_n = 1'b1;
        cycles(3);
        out_ready = 1'b1;
        exp_q.push_back(res(28, 7, 7, 7));
        send(7); send(7); send(7); send(7);
        chk("post-reset sum", out_sum, 28);
        cycles(1);

        // 16-sample window and drop saturation
        exp_q16.push_back(res(4080, 255, 255, 255));
        for (int i = 0; i < 16; i++) send16(8'd255);
        chk("win16 sum", out_sum16, 4080);
        chk("win16 avg", out_avg16, 255);
        for (int i = 0; i < 320; i++) send16(8'd255);
        chk("drop saturate", drop_cnt16, 255);
        out_ready16 = 1'b1;
        cycles(1);
        chk("win16 valid low", out_valid16, 0);

        cycles(2);
        chk("queue drained", exp_q.size(), 0);
        chk("queue16 drained", exp_q16.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/math_acc.md
MATH_ACC -- requirements
Module: math_acc

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 2; window length N = 2^WIN_LOG2 samples, legal range 1..4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_vio_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 8, registered result from the upstream math stage.
REQ-005 SHALL have port in_valid, input, 1, in_data sample strobe; one sample per high cycle, no backpressure upstream.
REQ-006 SHALL have port clear, input, 1, synchronous abort of the current window.
REQ-007 SHALL have port out_sum, output, 12, sum of the N samples in the window.
REQ-008 SHALL have port out_avg, output, 8, out_sum >> WIN_LOG2, truncated.
REQ-009 SHALL have port out_min, output, 8, smallest sample in the window.
REQ-010 SHALL have port out_max, output, 8, largest sample in the window.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, downstream accept; transfer occurs when out_valid && out_ready.
REQ-013 SHALL have port drop_cnt, output, 8, saturating count of samples lost while HOLD was full.

Function
REQ-014 SHALL implement the states ACCUM and HOLD, with the state machine entering ACCUM from reset.
REQ-015 In ACCUM, each in_valid SHALL add in_data to the 12-bit running sum, update running min/max, and increment the sample counter (WIN_LOG2+1 bits).
REQ-016 The first sample of a window SHALL load min = max = sum = in_data, not compare against stale values.
REQ-017 On the Nth sample, results SHALL be registered to the outputs, out_valid SHALL assert the next cycle, accumulators SHALL reset, and the state SHALL move to HOLD; latency from the Nth in_valid to out_valid is 1 cycle.
REQ-018 In HOLD, outputs SHALL stay stable while out_valid && !out_ready.
REQ-019 In HOLD, samples with in_valid SHALL accumulate into the next window (single result buffer plus live accumulator).
REQ-020 If the next window completes while HOLD is still unaccepted, that Nth sample and every further sample until acceptance SHALL be dropped, with drop_cnt incremented per dropped sample and saturating at 255; the accumulator holds N-1 samples meanwhile.
REQ-021 On transfer in HOLD: if the accumulator is complete (the case where the Nth sample arrives in the transfer cycle), the new result SHALL load in the same cycle, out_valid SHALL stay high, and the state SHALL remain HOLD; otherwise out_valid SHALL deassert next cycle and the state SHALL return to ACCUM.
REQ-022 Sum width SHALL be 12 bits; the maximum of 16*255 = 4080 fits, so no overflow is possible.
REQ-023 clear SHALL empty the accumulator and counter; it has priority over a simultaneous in_valid, which is discarded. Any held result and drop_cnt SHALL be kept.
REQ-024 Simultaneous in_valid and a transfer in the same cycle SHALL both take effect; no sample is lost unless per REQ-020.

Reset
REQ-025 Asserting reset_vio_n low SHALL immediately force: state ACCUM; out_valid 0; out_sum, out_avg, out_min, out_max 0; drop_cnt 0; counter 0.
REQ-026 Reset mid-window or mid-HOLD SHALL discard all partial and held data; the first in_valid after release starts a fresh window.
REQ-027 Deassertion SHALL be synchronised to clk internally (two-flop release) before it affects state.

Verification
REQ-028 WIN_LOG2=2, out_ready=1, samples 10,20,30,40 -> one cycle later out_sum=100, out_avg=25, out_min=10, out_max=40, out_valid=1 for exactly 1 cycle.
REQ-029 WIN_LOG2=2, out_ready=0, 12 consecutive samples of 255 -> first result held (sum 1020); 3 samples accumulate; 5 further samples dropped, drop_cnt=5; then out_ready=1 -> transfer, out_valid low next cycle.
REQ-030 clear asserted together with the 3rd in_valid of a window, then samples 1,2,3,4 -> result sum=10, min=1, max=4; the cleared samples do not contribute.
REQ-031 HOLD with accumulator at N-1, 4th sample arriving in the same cycle as out_ready=1 -> new result appears next cycle with out_valid continuously high; no drop.
REQ-032 reset_vio_n pulsed low asynchronously mid-HOLD (no clk edge) -> out_valid and all outputs read 0 immediately; after release, 4 samples of 7 -> out_sum=28.
REQ-033 WIN_LOG2=4, 16 samples of 255 -> out_sum=4080, out_avg=255; more than 300 dropped samples with out_ready=0 -> drop_cnt=255.
